// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the TDP36 RAM-backed streaming FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DATA_W             = 36;
    localparam int unsigned ADDR_W             = 10;
    localparam int unsigned DEPTH              = 1 << ADDR_W;
    localparam int unsigned RD_LAT             = 2;
    localparam int unsigned OBUF_DEPTH         = 4;
    localparam int unsigned CNT_W              = ADDR_W + 1;
    localparam int unsigned OBUF_IDX_W         = 2;
    localparam int unsigned OBUF_CNT_W         = 3;
    localparam int unsigned CREDIT_W           = 4;
    localparam int unsigned ALMOST_FULL_MARGIN = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/ram_tdp36_stream_fifo_ctrl_if.sv
// Upstream and downstream valid/ready streams of the RAM FIFO controller.
interface ram_tdp36_stream_fifo_ctrl_if;
    import ram_fifo_pkg::*;

    logic  s_valid;
    logic  s_ready;
    word_t s_data;
    logic  m_valid;
    logic  m_ready;
    word_t m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/ram_fifo_out_buf.sv
// Small output FIFO that absorbs words returning from the RAM read pipeline.
module ram_fifo_out_buf
    import ram_fifo_pkg::*;
(
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  word_t                 pushData,
    output word_t                 headData,
    output logic [OBUF_CNT_W-1:0] cnt
);

    word_t                 mem [OBUF_DEPTH];
    logic [OBUF_IDX_W-1:0] wrIdx;
    logic [OBUF_IDX_W-1:0] rdIdx;
    logic                  popEn;

    assign popEn    = pop && (cnt != '0);
    assign headData = (cnt != '0) ? mem[rdIdx] : '0;

    always_ff @(posedge clock0) begin
        if (reset) begin
            wrIdx <= '0;
            rdIdx <= '0;
            cnt   <= '0;
        end else begin
            if (push)  wrIdx <= wrIdx + OBUF_IDX_W'(1);
            if (popEn) rdIdx <= rdIdx + OBUF_IDX_W'(1);
            unique case ({push, popEn})
                2'b10:   cnt <= cnt + OBUF_CNT_W'(1);
                2'b01:   cnt <= cnt - OBUF_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; cnt gates visibility of stale entries.
    always_ff @(posedge clock0) begin
        if (push) mem[wrIdx] <= pushData;
    end

endmodule

// File: rtl/ram_tdp36_stream_fifo_ctrl.sv
// Streaming FIFO over a 1024x36 TDP RAM with credit-tracked read prefetch.
// Optional RAM_FIFO_LEVEL_EN adds level and almost_full outputs.
module ram_tdp36_stream_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic                              clock0,
    input  logic                              reset,
    ram_tdp36_stream_fifo_ctrl_if.slave       streamIf,
    output logic                              ram_weA,
    output ptr_t                              ram_addrA,
    output word_t                             ram_dinA,
    output logic                              ram_weB,
    output ptr_t                              ram_addrB,
    input  word_t                             ram_doutB
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output cnt_t                              level,
    output logic                              almost_full
`endif
);

    ptr_t                  wrPtr;
    ptr_t                  rdPtr;
    cnt_t                  ramCnt;
    logic                  v1;
    logic                  v2;
    logic [OBUF_CNT_W-1:0] obufCnt;
    logic [CREDIT_W-1:0]   credit;
    logic                  accept;
    logic                  issue;
    logic                  pop;

    assign streamIf.s_ready = !reset && (ramCnt < CNT_W'(DEPTH));
    assign accept           = streamIf.s_valid && streamIf.s_ready;

    // Issue only if the word has a guaranteed slot in the output buffer on arrival.
    assign credit = CREDIT_W'(v1) + CREDIT_W'(v2) + CREDIT_W'(obufCnt);
    assign issue  = !reset && (ramCnt != '0) && (credit <= CREDIT_W'(OBUF_DEPTH - 1));

    assign ram_weA   = accept;
    assign ram_addrA = wrPtr;
    assign ram_dinA  = accept ? streamIf.s_data : '0;
    assign ram_weB   = 1'b0;
    assign ram_addrB = rdPtr;

    assign streamIf.m_valid = (obufCnt != '0);
    assign pop              = streamIf.m_valid && streamIf.m_ready;

    always_ff @(posedge clock0) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            ramCnt <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
        end else begin
            if (accept) wrPtr <= wrPtr + ADDR_W'(1);
            if (issue)  rdPtr <= rdPtr + ADDR_W'(1);
            v1 <= issue;
            v2 <= v1;
            unique case ({accept, issue})
                2'b10:   ramCnt <= ramCnt + CNT_W'(1);
                2'b01:   ramCnt <= ramCnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // v2 marks the single cycle in which ram_doutB carries the issued word.
    ram_fifo_out_buf u_obuf (
        .clock0   (clock0),
        .reset    (reset),
        .push     (v2),
        .pop      (pop),
        .pushData (ram_doutB),
        .headData (streamIf.m_data),
        .cnt      (obufCnt)
    );

`ifdef RAM_FIFO_LEVEL_EN
    always_ff @(posedge clock0) begin
        if (reset) level <= '0;
        else       level <= ramCnt + CNT_W'(v1) + CNT_W'(v2) + CNT_W'(obufCnt);
    end

    assign almost_full = (ramCnt >= CNT_W'(DEPTH - ALMOST_FULL_MARGIN));
`endif

endmodule

// File: doc/ram_tdp36_stream_fifo_ctrl.md
Name: ram_tdp36_stream_fifo_ctrl

Overview:
- Single-clock FIFO controller that wraps the 1024x36 true-dual-port RAM with registered outputs as a streaming FIFO.
- Upstream valid/ready stream is written through RAM port A; entries are read back through port B.
- Handles the RAM's 2-cycle read latency (array read plus output register) with credit-tracked prefetch into a small output buffer.
- Downstream stream runs at full throughput.

Parameters:
- DATA_W, 36, word width; must match RAM port width.
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W = 1024.
- RD_LAT, 2, cycles from addrB sampled to data on ram_doutB; fixed by the RAM's output register.
- OBUF_DEPTH, 4, output buffer entries; must be ≥ RD_LAT+2.

Ports:
- clock0, input, 1, sole clock; also drives both RAM clocks.
- reset, input, 1, synchronous active-high reset.
- s_valid, input, 1, upstream word valid.
- s_ready, output, 1, controller can accept a word.
- s_data, input, 36, upstream word.
- m_valid, output, 1, downstream word valid.
- m_ready, input, 1, downstream accepts.
- m_data, output, 36, downstream word (head of output buffer).
- ram_weA, output, 1, RAM port A write enable.
- ram_addrA, output, 10, RAM port A address.
- ram_dinA, output, 36, RAM port A write data.
- ram_weB, output, 1, RAM port B write enable; tied 0, so port B reads every cycle.
- ram_addrB, output, 10, RAM port B address.
- ram_doutB, input, 36, RAM port B registered read data.

Behaviour:
- Interface: one clock (clock0); reset is synchronous and active-high (reset).
- Reset values:
  - wr_ptr, rd_ptr, ram_cnt (11b), v1, v2 = 0; output buffer empty.
  - s_ready=0 while reset is high, 1 in the first cycle after.
  - m_valid=0, m_data=0, ram_weA=0, ram_addrA=0, ram_dinA=0, ram_addrB=0, ram_weB=0.
  - Reset mid-operation discards all RAM contents, in-flight reads and buffered words; RAM array contents are not cleared.
- Write path:
  - s_ready = (ram_cnt < DEPTH), registered-state only; no combinational path from m_ready.
  - Accept when s_valid & s_ready: ram_weA=1, ram_addrA=wr_ptr, ram_dinA=s_data (combinational, same cycle).
  - wr_ptr increments modulo 1024 at that edge.
- Read issue:
  - issue = (ram_cnt != 0) & (v1 + v2 + obuf_cnt ≤ OBUF_DEPTH-1).
  - ram_addrB = rd_ptr at all times.
  - On issue, rd_ptr increments modulo 1024 at the edge; v1 <= issue; v2 <= v1.
  - When v2=1, ram_doutB holds the issued word for that cycle only and is pushed into the output buffer at the next edge.
- ram_cnt update at each edge: +1 on accept, -1 on issue; both together leave it unchanged.
  - A word written at edge E0 is issuable in the cycle after E0. Collision-free: only committed entries are read, only free entries written.
- Output buffer:
  - 4-entry FIFO; m_valid = obuf_cnt != 0.
  - Pop on m_valid & m_ready; push and pop in the same cycle are allowed, including when full or empty.
  - The credit rule guarantees no overflow.
- Latency: accept at edge E0 → issue cycle after E0 → m_valid high after edge E3 with an empty pipe (3-cycle first-word latency).
- Throughput: one word/cycle sustained with m_ready held high.
- Capacity: 1024 RAM entries + up to 4 buffered words.
- Wrap: pointers roll 1023→0 with no gap. At full (ram_cnt=1024), an issue frees a slot visible one cycle later.

Optional Feature:
- Macro: RAM_FIFO_LEVEL_EN.
- Defined: adds output level[10:0] = ram_cnt + v1 + v2 + obuf_cnt, registered, reset 0, and output almost_full = ram_cnt ≥ DEPTH-16.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ram_fifo_pkg holds DATA_W, ADDR_W, DEPTH, RD_LAT, OBUF_DEPTH, and the count/pointer widths.
- One sub-module, ram_fifo_out_buf: 4-entry synchronous FIFO with push/pop and cnt output.
- Pointers, credit logic and RAM port drive stay in the top module.

Test Plan:
- Single word: reset, write 36'h9_ABCD_1234 once, m_ready=1 → m_valid rises exactly 3 cycles after the accept edge, m_data=36'h9_ABCD_1234, m_valid low the next cycle.
- Streaming: 2000 sequential words, s_valid=1, m_ready=1 → after first-word latency, one word/cycle out in order; ram_cnt never exceeds 4.
- Fill: m_ready=0, write until s_ready=0 → exactly 1028 accepts (4 prefetched, 1024 in RAM); then m_ready=1 drains 1028 words in order and s_ready reasserts one cycle after the first issue.
- Backpressure: random m_ready (50%) with continuous writes across ≥3 pointer wraps → no loss, duplication or reorder; output buffer never overflows.
- Reset mid-stream: reset asserted with 500 words stored and v1=v2=1 → next cycle m_valid=0, s_ready=0; after release, new data 36'h1 emerges first.
- RAM_FIFO_LEVEL_EN build: write 20 words with m_ready=0 → level=20, almost_full=0. Fill to ram_cnt=1008 → almost_full=1.
